// File: rtl/hilo_issue_ctrl_pkg.sv
// Shared encodings for the HI/LO issue controller: EX op codes, engine op codes, FSM states.
package hilo_issue_ctrl_pkg;

   typedef enum logic [3:0] {
      HIOP_NOP   = 4'd0,
      HIOP_MULT  = 4'd1,
      HIOP_MULTU = 4'd2,
      HIOP_DIV   = 4'd3,
      HIOP_DIVU  = 4'd4,
      HIOP_MFHI  = 4'd5,
      HIOP_MFLO  = 4'd6,
      HIOP_MTHI  = 4'd7,
      HIOP_MTLO  = 4'd8
   } hiop_e;

   typedef enum logic [1:0] {
      ENG_MULT  = 2'd0,
      ENG_MULTU = 2'd1,
      ENG_DIV   = 2'd2,
      ENG_DIVU  = 2'd3
   } eng_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   // Codes 9..15 decode as NOP, so only 1..8 count as real HI/LO ops.
   function automatic logic is_hilo_op(input logic [3:0] code);
      return (code >= 4'd1) && (code <= 4'd8);
   endfunction

   function automatic eng_op_e to_eng_op(input logic [3:0] code);
      case (code)
         HIOP_MULTU: return ENG_MULTU;
         HIOP_DIV:   return ENG_DIV;
         HIOP_DIVU:  return ENG_DIVU;
         default:    return ENG_MULT;
      endcase
   endfunction

endpackage

// File: rtl/hilo_issue_ctrl.sv
// HI/LO issuer: decodes EX HI/LO ops, hands mult/div to the engine over req/ack + done,
// and owns the architectural HI/LO registers and the MFHI/MFLO read port.
//   state   | meaning
//   ST_IDLE | no engine op outstanding; ops from EX are executed or issued
//   ST_REQ  | eng_req held with stable operands until eng_ack
//   ST_WAIT | acked, counting toward TIMEOUT while waiting for eng_done
module hilo_issue_ctrl
   import hilo_issue_ctrl_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   input  logic [3:0]       op_code,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             stall,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             eng_req,
   output logic [1:0]       eng_op,
   output logic [WIDTH-1:0] eng_a,
   output logic [WIDTH-1:0] eng_b,
   input  logic             eng_ack,
   input  logic             eng_done,
   input  logic [WIDTH-1:0] eng_hi,
   input  logic [WIDTH-1:0] eng_lo,
   output logic             div0,
   output logic             tmo,
   output logic [WIDTH-1:0] hi_q,
   output logic [WIDTH-1:0] lo_q
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_e           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_hi, r_lo, r_eng_a, r_eng_b;
   eng_op_e          r_eng_op;
   logic             r_eng_req, r_div0, r_tmo;

   logic w_busy, w_mfhi, w_mflo, w_div_op, w_div_zero;

   assign w_busy     = (r_state != ST_IDLE);
   assign w_mfhi     = op_valid && !w_busy && (op_code == HIOP_MFHI);
   assign w_mflo     = op_valid && !w_busy && (op_code == HIOP_MFLO);
   assign w_div_op   = (op_code == HIOP_DIV) || (op_code == HIOP_DIVU);
   assign w_div_zero = (rt_val == '0);

   assign stall    = op_valid && is_hilo_op(op_code) && w_busy;
   assign rd_valid = w_mfhi || w_mflo;
   assign rd_data  = w_mfhi ? r_hi : (w_mflo ? r_lo : '0);

   assign eng_req = r_eng_req;
   assign eng_op  = r_eng_op;
   assign eng_a   = r_eng_a;
   assign eng_b   = r_eng_b;
   assign div0    = r_div0;
   assign tmo     = r_tmo;
   assign hi_q    = r_hi;
   assign lo_q    = r_lo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_eng_a   <= '0;
         r_eng_b   <= '0;
         r_eng_op  <= ENG_MULT;
         r_eng_req <= 1'b0;
         r_div0    <= 1'b0;
         r_tmo     <= 1'b0;
      end else begin
         r_div0 <= 1'b0;
         r_tmo  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (op_valid) begin
                  case (op_code)
                     HIOP_MULT, HIOP_MULTU, HIOP_DIV, HIOP_DIVU: begin
                        if (w_div_op && w_div_zero) begin
                           r_div0 <= 1'b1;
                        end else begin
                           r_eng_a   <= rs_val;
                           r_eng_b   <= rt_val;
                           r_eng_op  <= to_eng_op(op_code);
                           r_eng_req <= 1'b1;
                           r_state   <= ST_REQ;
                        end
                     end
                     HIOP_MTHI: r_hi <= rs_val;
                     HIOP_MTLO: r_lo <= rs_val;
                     default: ;
                  endcase
               end
            end
            ST_REQ: begin
               if (eng_ack) begin
                  r_eng_req <= 1'b0;
                  r_cnt     <= '0;
                  if (eng_done) begin
                     r_hi    <= eng_hi;
                     r_lo    <= eng_lo;
                     r_state <= ST_IDLE;
                  end else begin
                     r_state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               // done wins over a timeout landing on the same cycle
               if (eng_done) begin
                  r_hi    <= eng_hi;
                  r_lo    <= eng_lo;
                  r_state <= ST_IDLE;
               end else if (r_cnt == CNT_LAST) begin
                  r_tmo   <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_eng_req <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_issue_ctrl.sv
// Bench for hilo_issue_ctrl: bench-side mult/div engine, cycle scoreboard fed by a
// behavioural HI/LO model, and a negedge monitor that pops and compares.
module tb_hilo_issue_ctrl;
   import hilo_issue_ctrl_pkg::*;

   localparam int W  = 32;
   localparam int TO = 64;

   logic         clk, rst_n, op_valid;
   logic [3:0]   op_code;
   logic [W-1:0] rs_val, rt_val, rd_data, eng_a, eng_b, eng_hi, eng_lo, hi_q, lo_q;
   logic         stall, rd_valid, eng_req, eng_ack, eng_done, div0, tmo;
   logic [1:0]   eng_op;

   hilo_issue_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
      .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .rd_data(rd_data),
      .rd_valid(rd_valid), .eng_req(eng_req), .eng_op(eng_op), .eng_a(eng_a),
      .eng_b(eng_b), .eng_ack(eng_ack), .eng_done(eng_done), .eng_hi(eng_hi),
      .eng_lo(eng_lo), .div0(div0), .tmo(tmo), .hi_q(hi_q), .lo_q(lo_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         stall;
      logic         rdv;
      logic         req;
      logic         div0;
      logic         tmo;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } exp_t;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } iss_t;

   exp_t         q_cyc[$];
   logic [W-1:0] q_rd[$];
   iss_t         q_iss[$];
   int           n_chk = 0;
   int           n_err = 0;

   // reference model: architectural HI/LO plus "an engine op is outstanding"
   logic [W-1:0] m_hi, m_lo;
   bit           m_busy, m_req, m_pd0, m_ptmo;
   int           m_ack_cyc, cyc_n;

   // bench engine
   int           e_phase, e_cnt, cfg_ack, cfg_done;
   bit           cfg_same, cfg_never, cfg_stray, rand_eng;
   iss_t         e_cur;
   logic [63:0]  e_res;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual %0h required %0h (cycle %0d)", nm, act, req, cyc_n);
      end
   endtask

   function automatic logic [63:0] calc(input logic [1:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
      longint      sa, sb;
      logic [63:0] ua, ub, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'h0, a};
      ub = {32'h0, b};
      if (op[1] && b == '0) return '0;
      case (op)
         2'd0: return 64'(sa * sb);
         2'd1: return ua * ub;
         2'd2: begin
            q = 64'(sa / sb);
            r = 64'(sa % sb);
            return {r[31:0], q[31:0]};
         end
         default: begin
            q = ua / ub;
            r = ua % ub;
            return {r[31:0], q[31:0]};
         end
      endcase
   endfunction

   exp_t mon_e;
   always @(negedge clk) begin
      if (q_cyc.size() > 0) begin
         mon_e = q_cyc.pop_front();
         chk("stall", stall, mon_e.stall);
         chk("rd_valid", rd_valid, mon_e.rdv);
         chk("eng_req", eng_req, mon_e.req);
         chk("div0", div0, mon_e.div0);
         chk("tmo", tmo, mon_e.tmo);
         chk("hi_q", hi_q, mon_e.hi);
         chk("lo_q", lo_q, mon_e.lo);
         if (rd_valid) begin
            if (q_rd.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL rd_data actual %0h required no read", rd_data);
            end else begin
               chk("rd_data", rd_data, q_rd.pop_front());
            end
         end
      end
   end

   // One clock cycle: engine reacts, inputs are driven, expectations pushed, model advanced.
   task automatic cyc(input logic v, input logic [3:0] c, input logic [W-1:0] a,
                      input logic [W-1:0] b);
      exp_t         e;
      iss_t         t;
      logic         ack, done;
      logic [W-1:0] dh, dl;
      @(posedge clk);
      #1;
      ack = 1'b0; done = 1'b0; dh = '0; dl = '0;
      if (e_phase == 0 && eng_req) begin
         if (rand_eng) begin
            cfg_ack   = $urandom_range(0, 3);
            cfg_done  = $urandom_range(0, 5);
            cfg_same  = ($urandom_range(0, 5) == 0);
            cfg_never = ($urandom_range(0, 9) == 0);
         end
         if (q_iss.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL eng_issue actual request required none");
            e_cur = '{op: eng_op, a: eng_a, b: eng_b};
         end else begin
            e_cur = q_iss.pop_front();
         end
         e_res   = calc(e_cur.op, e_cur.a, e_cur.b);
         e_phase = 1;
         e_cnt   = cfg_ack;
      end
      if (e_phase == 1) begin
         chk("req_hold", eng_req, 1'b1);
         chk("eng_a", eng_a, e_cur.a);
         chk("eng_b", eng_b, e_cur.b);
         chk("eng_op", eng_op, e_cur.op);
         if (e_cnt == 0) begin
            ack = 1'b1;
            if (cfg_same) begin
               done = 1'b1; {dh, dl} = e_res; e_phase = 0;
            end else begin
               e_phase = 2; e_cnt = cfg_done;
            end
         end else begin
            e_cnt--;
         end
      end else if (e_phase == 2) begin
         if (!cfg_never) begin
            if (e_cnt == 0) begin
               done = 1'b1; {dh, dl} = e_res; e_phase = 0;
            end else begin
               e_cnt--;
            end
         end
      end else if (cfg_stray || (rand_eng && $urandom_range(0, 9) == 0)) begin
         done = 1'b1; dh = $urandom; dl = $urandom; cfg_stray = 1'b0;
      end

      eng_ack = ack; eng_done = done; eng_hi = dh; eng_lo = dl;
      op_valid = v; op_code = c; rs_val = a; rt_val = b;

      e.stall = v && (c >= 4'd1) && (c <= 4'd8) && m_busy;
      e.rdv   = v && !m_busy && (c == HIOP_MFHI || c == HIOP_MFLO);
      e.req   = m_req;
      e.div0  = m_pd0;
      e.tmo   = m_ptmo;
      e.hi    = m_hi;
      e.lo    = m_lo;
      q_cyc.push_back(e);
      if (e.rdv) q_rd.push_back((c == HIOP_MFHI) ? m_hi : m_lo);
      m_pd0 = 1'b0; m_ptmo = 1'b0;

      if (m_busy) begin
         if (m_req) begin
            if (ack) begin
               m_req = 1'b0;
               if (done) begin
                  m_hi = dh; m_lo = dl; m_busy = 1'b0;
               end else begin
                  m_ack_cyc = cyc_n;
               end
            end
         end else if (done) begin
            m_hi = dh; m_lo = dl; m_busy = 1'b0;
         end else if (cyc_n == m_ack_cyc + TO) begin
            // the engine gets TO cycles after the ack cycle; pulse follows
            m_busy = 1'b0; m_ptmo = 1'b1; e_phase = 0;
         end
      end else if (v) begin
         if ((c >= 4'd1 && c <= 4'd4) && !((c == HIOP_DIV || c == HIOP_DIVU) && b == '0)) begin
            t.op = 2'(c - 4'd1); t.a = a; t.b = b;
            q_iss.push_back(t);
            m_busy = 1'b1; m_req = 1'b1;
         end else if (c == HIOP_DIV || c == HIOP_DIVU) begin
            m_pd0 = 1'b1;
         end else if (c == HIOP_MTHI) begin
            m_hi = a;
         end else if (c == HIOP_MTLO) begin
            m_lo = a;
         end
      end
      cyc_n++;
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int           n;
      logic         v;
      logic [3:0]   c;
      logic [W-1:0] a, b;
      rst_n = 1'b0; op_valid = 1'b0; op_code = '0; rs_val = '0; rt_val = '0;
      eng_ack = 1'b0; eng_done = 1'b0; eng_hi = '0; eng_lo = '0;
      m_hi = '0; m_lo = '0; m_busy = 0; m_req = 0; m_pd0 = 0; m_ptmo = 0;
      m_ack_cyc = 0; cyc_n = 0; e_phase = 0; e_cnt = 0;
      cfg_ack = 0; cfg_done = 0; cfg_same = 0; cfg_never = 0; cfg_stray = 0; rand_eng = 0;
      #3;
      chk("rst_hi_q", hi_q, 0);
      chk("rst_lo_q", lo_q, 0);
      chk("rst_eng_req", eng_req, 0);
      chk("rst_eng_ab", {eng_a, eng_b}, 0);
      chk("rst_eng_op", eng_op, 0);
      chk("rst_pulses", {div0, tmo, stall, rd_valid}, 0);
      chk("rst_rd_data", rd_data, 0);
      #9 rst_n = 1'b1;

      // MULT -1 * 2, ack in first REQ cycle, done four cycles after ack
      cfg_ack = 0; cfg_done = 3; cfg_same = 0; cfg_never = 0;
      cyc(1, HIOP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1, HIOP_MFLO, '0, '0);
         if (stall) n++;
         else break;
      end
      chk("mult_stall_cycles", n, 5);
      chk("mult_rd_data", rd_data, 32'hFFFF_FFFE);
      chk("mult_rd_valid", rd_valid, 1);
      chk("mult_hi_q", hi_q, 32'hFFFF_FFFF);

      // divide by zero
      cyc(1, HIOP_MTHI, 32'h1234_5678, '0);
      cyc(1, HIOP_MTLO, 32'h9ABC_DEF0, '0);
      cyc(1, HIOP_DIV, 32'd7, '0);
      chk("div0_no_stall", stall, 0);
      cyc(0, HIOP_NOP, '0, '0);
      chk("div0_pulse", div0, 1);
      chk("div0_no_req", eng_req, 0);
      chk("div0_hi_kept", hi_q, 32'h1234_5678);
      chk("div0_lo_kept", lo_q, 32'h9ABC_DEF0);

      // MTHI then MFHI back to back
      cyc(1, HIOP_MTHI, 32'hA5A5_A5A5, '0);
      cyc(1, HIOP_MFHI, '0, '0);
      chk("mthi_rd_data", rd_data, 32'hA5A5_A5A5);
      chk("mthi_rd_valid", rd_valid, 1);
      chk("mthi_no_stall", stall, 0);

      // DIVU 100/7, ack withheld three cycles, ack+done together
      cfg_ack = 3; cfg_same = 1;
      cyc(1, HIOP_DIVU, 32'd100, 32'd7);
      for (int i = 0; i < 3; i++) begin
         cyc(0, HIOP_NOP, '0, '0);
         chk("divu_req_held", {eng_req, eng_a, eng_b}, {1'b1, 32'd100, 32'd7});
      end
      cyc(0, HIOP_NOP, '0, '0);
      cyc(1, HIOP_MFLO, '0, '0);
      chk("divu_idle_no_stall", stall, 0);
      chk("divu_lo_q", lo_q, 14);
      chk("divu_hi_q", hi_q, 2);

      // MULTU with no done: timeout, then a late done is ignored
      cfg_ack = 0; cfg_same = 0; cfg_never = 1;
      cyc(1, HIOP_MULTU, $urandom, $urandom);
      cyc(0, HIOP_NOP, '0, '0);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         cyc(0, HIOP_NOP, '0, '0);
         n++;
         if (tmo) break;
      end
      chk("tmo_latency", n, TO + 1);
      chk("tmo_hi_kept", hi_q, 2);
      cfg_stray = 1;
      cyc(0, HIOP_NOP, '0, '0);
      cyc(1, HIOP_MFLO, '0, '0);
      chk("late_done_lo", rd_data, 14);
      chk("late_done_hi", hi_q, 2);

      // randomized traffic against the model
      rand_eng = 1;
      for (int i = 0; i < 800; i++) begin
         v = ($urandom_range(0, 9) < 7);
         c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
         cyc(v, c, a, b);
      end
      rand_eng = 0;
      for (int i = 0; i < 200 && m_busy; i++) cyc(0, HIOP_NOP, '0, '0);
      chk("drain_idle", m_busy, 0);

      // reset while waiting on the engine
      cfg_ack = 0; cfg_same = 0; cfg_never = 1;
      cyc(1, HIOP_MULT, 32'd3, 32'd5);
      cyc(0, HIOP_NOP, '0, '0);
      cyc(0, HIOP_NOP, '0, '0);
      cyc(0, HIOP_NOP, '0, '0);
      @(negedge clk);
      #2;
      op_valid = 1'b1; op_code = HIOP_MFLO;
      #1;
      chk("wait_busy_stall", stall, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_eng_req", eng_req, 0);
      chk("rst_mid_hilo", {hi_q, lo_q}, 0);
      chk("rst_mid_idle", {stall, rd_valid, rd_data}, {2'b01, 32'h0});
      m_hi = '0; m_lo = '0; m_busy = 0; m_req = 0; m_pd0 = 0; m_ptmo = 0;
      e_phase = 0; q_iss.delete();
      @(posedge clk);
      #3 rst_n = 1'b1;
      cfg_stray = 1;
      cyc(0, HIOP_NOP, '0, '0);
      cyc(1, HIOP_MFLO, '0, '0);
      chk("post_rst_mflo", rd_data, 0);
      chk("post_rst_lo_q", lo_q, 0);

      @(negedge clk);
      @(negedge clk);
      chk("rd_queue_empty", q_rd.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
